// File: rtl/lsu_axi_master.sv
// lsu_axi_master: bridges the core load/store port onto an AXI4-Lite master.
// One transaction is in flight at a time; the core is stalled through hold_o
// until the completion pulse (rdone_o / wdone_o) is issued.
//
// Handshake semantics (all AXI channels): a transfer happens on a rising edge
// where both valid and ready are 1. Once a valid is raised, it and its payload
// stay unchanged until that transfer. The valids and readys driven here come
// only from registers; none of them depends combinationally on an input.
module lsu_axi_master #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  // core load/store port
  input  logic                  ren_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  input  logic                  wen_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wmask_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  rdone_o,
  output logic                  wdone_o,
  output logic                  err_o,
  output logic                  hold_o,
  // AXI write address channel
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [ADDR_W-1:0]     awaddr_o,
  // AXI write data channel
  output logic                  wvalid_o,
  input  logic                  wready_i,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  // AXI write response channel
  input  logic                  bvalid_i,
  output logic                  bready_o,
  input  logic [1:0]            bresp_i,
  // AXI read address channel
  output logic                  arvalid_o,
  input  logic                  arready_i,
  output logic [ADDR_W-1:0]     araddr_o,
  // AXI read data channel
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [DATA_W-1:0]     rdata_i,
  input  logic [1:0]            rresp_i,
  // debug view of the controller state
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4
  } state_t;

  state_t state;
  logic   done_q;
  logic   aw_left;
  logic   w_left;

  assign state_o = state;

  // A completion pulse marks the cycle in which the finished request is still
  // presented by the core; it is neither stalled nor re-accepted.
  assign done_q = rdone_o | wdone_o;

  // Stall while busy, or while a fresh request waits in IDLE.
  assign hold_o = (state != S_IDLE) | ((ren_i | wen_i) & ~done_q);

  // A write channel is still outstanding if its valid is up and not accepted now.
  assign aw_left = awvalid_o & ~awready_i;
  assign w_left  = wvalid_o & ~wready_i;

  // Transaction controller with registered AXI controls and core responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      awvalid_o <= 1'b0;
      wvalid_o  <= 1'b0;
      bready_o  <= 1'b0;
      arvalid_o <= 1'b0;
      rready_o  <= 1'b0;
      awaddr_o  <= '0;
      wdata_o   <= '0;
      wstrb_o   <= '0;
      araddr_o  <= '0;
      rdata_o   <= '0;
      rdone_o   <= 1'b0;
      wdone_o   <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      rdone_o <= 1'b0;
      wdone_o <= 1'b0;
      err_o   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!done_q && wen_i) begin
            awaddr_o  <= waddr_i;
            wdata_o   <= wdata_i;
            wstrb_o   <= wmask_i;
            awvalid_o <= 1'b1;
            wvalid_o  <= 1'b1;
            state     <= S_WR_REQ;
          end else if (!done_q && ren_i) begin
            araddr_o  <= raddr_i;
            arvalid_o <= 1'b1;
            state     <= S_RD_REQ;
          end
        end
        S_WR_REQ: begin
          if (awvalid_o && awready_i) awvalid_o <= 1'b0;
          if (wvalid_o && wready_i)   wvalid_o  <= 1'b0;
          if (!aw_left && !w_left) begin
            bready_o <= 1'b1;
            state    <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid_i) begin
            bready_o <= 1'b0;
            wdone_o  <= 1'b1;
            err_o    <= (bresp_i != 2'b00);
            state    <= S_IDLE;
          end
        end
        S_RD_REQ: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state     <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid_i) begin
            rready_o <= 1'b0;
            rdata_o  <= rdata_i;
            rdone_o  <= 1'b1;
            err_o    <= (rresp_i != 2'b00);
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
